// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals shared by the arbiter and its neighbours.
// Handshake: a requester raises *_req with its address/data stable and holds them until the matching *_gnt is seen high in the same cycle; a grant consumes the request.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_func3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store: data side wins unless fetch has been
// denied STARVE_MAX cycles in a row. Read data returns registered one cycle after the grant.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0]  starve_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [2:0]       F3_WORD = 3'b010;

    logic             force_if;
    logic             if_gnt;
    logic             d_gnt;
    logic [CNT_W-1:0] cnt_q;
    logic             if_rvalid_q;
    logic             d_rvalid_q;
    logic [31:0]      if_rdata_q;
    logic [31:0]      d_rdata_q;

    // Grants are killed during reset so no store can reach memory.
    always_comb begin
        force_if = bus.if_req && (cnt_q == CNT_MAX);
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        if (!rst) begin
            if (force_if) begin
                if_gnt = 1'b1;
            end else if (bus.d_req) begin
                d_gnt = 1'b1;
            end else if (bus.if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_func3 = 3'b000;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        if (if_gnt) begin
            bus.mem_read  = 1'b1;
            bus.mem_func3 = F3_WORD;
            bus.mem_addr  = bus.if_addr;
        end else if (d_gnt) begin
            bus.mem_read  = !bus.d_we;
            bus.mem_write = bus.d_we;
            bus.mem_func3 = bus.d_func3;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            // Counts only cycles where fetch wanted the port and lost it.
            if (if_gnt || !bus.if_req) begin
                cnt_q <= '0;
            end else if (d_gnt && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if_rvalid_q <= if_gnt;
            d_rvalid_q  <= d_gnt && !bus.d_we;
            if (if_gnt) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (d_gnt && !bus.d_we) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign starve_cnt    = cnt_q;

    // A pending request may not be withdrawn or changed before it is granted.
    property p_if_hold;
        @(posedge clk) disable iff (rst)
            (bus.if_req && !bus.if_gnt) |=> (bus.if_req && $stable(bus.if_addr));
    endproperty
    a_if_hold: assert property (p_if_hold);

    property p_d_hold;
        @(posedge clk) disable iff (rst)
            (bus.d_req && !bus.d_gnt) |=>
                (bus.d_req && $stable({bus.d_we, bus.d_func3, bus.d_addr, bus.d_wdata}));
    endproperty
    a_d_hold: assert property (p_d_hold);
endmodule
